// File: rtl/mux_rr_reg_pkg.sv
// Shared constants and helpers for the registered round-robin channel mux.
package mux_rr_reg_pkg;

  // Selection mode encodings for the i_mode input
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Default geometry
  localparam int unsigned DEF_N_CH  = 4;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_SEL_W = 2;

  // Low bit index of channel ch inside a packed multi-channel bus
  function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request at or after
// i_start (wrapping modulo N_CH) using a double-width rotate and a priority search.
module rr_pick
  import mux_rr_reg_pkg::*;
#(
  parameter int unsigned N_CH  = DEF_N_CH,
  parameter int unsigned SEL_W = DEF_SEL_W
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [SEL_W-1:0] i_start,
  output logic [N_CH-1:0]  o_grant,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  logic [2*N_CH-1:0] w_req_dbl;
  logic [2*N_CH-1:0] w_req_shr;
  logic [N_CH-1:0]   w_req_rot;
  logic [N_CH-1:0]   w_gnt_rot;
  logic [2*N_CH-1:0] w_gnt_dbl;
  logic [2*N_CH-1:0] w_gnt_shl;

  // Rotate requests so i_start lands at bit 0; the upper half only ever holds
  // a subset of the lower half, so OR-folding keeps every bit in use.
  assign w_req_dbl = {i_req, i_req};
  assign w_req_shr = w_req_dbl >> i_start;
  assign w_req_rot = w_req_shr[N_CH-1:0] | w_req_shr[2*N_CH-1:N_CH];

  // Lowest set bit of the rotated request wins
  always_comb begin
    logic found;
    found     = 1'b0;
    w_gnt_rot = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (!found && w_req_rot[i]) begin
        w_gnt_rot[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Rotate the grant back into channel order
  assign w_gnt_dbl = {w_gnt_rot, w_gnt_rot};
  assign w_gnt_shl = w_gnt_dbl << i_start;
  assign o_grant   = w_gnt_shl[2*N_CH-1:N_CH] | w_gnt_shl[N_CH-1:0];

  // Encode the one-hot grant
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (o_grant[i]) o_idx = o_idx | SEL_W'(i);
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel mux with fixed or round-robin selection, per-channel valid/ready
// and a single registered output stage.
module mux_rr_reg
  import mux_rr_reg_pkg::*;
#(
  parameter int unsigned N_CH  = DEF_N_CH,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEL_W = DEF_SEL_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [N_CH*WIDTH-1:0] i_in_data,
  input  logic [N_CH-1:0]       i_in_valid,
  output logic [N_CH-1:0]       o_in_ready,
  output logic [WIDTH-1:0]      o_out_data,
  output logic [SEL_W-1:0]      o_out_ch,
  output logic                  o_out_valid,
  input  logic                  i_out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_is_rr;
  logic             w_load;
  logic [N_CH-1:0]  w_fix_grant;
  logic [N_CH-1:0]  w_rr_grant;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_rr_any;
  logic             w_any;
  logic [N_CH-1:0]  w_grant;
  logic [SEL_W-1:0] w_sel_idx;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_xfer;

  assign w_is_rr = (i_mode == MODE_RR);
  assign w_load  = !r_out_valid || i_out_ready;

  // Fixed select: an out-of-range sel simply matches no channel
  always_comb begin
    w_fix_grant = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      w_fix_grant[i] = i_in_valid[i] && (i_sel == SEL_W'(i));
    end
  end

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .i_req   (i_in_valid),
    .i_start (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  // No grant may issue while reset is asserted
  assign w_grant    = (w_is_rr ? w_rr_grant : w_fix_grant) & {N_CH{i_rst_n}};
  assign w_any      = w_is_rr ? w_rr_any : (|w_fix_grant);
  assign w_sel_idx  = w_is_rr ? w_rr_idx : i_sel;
  assign o_in_ready = w_grant & {N_CH{w_load}};
  assign w_xfer     = i_rst_n && w_load && w_any;

  // One-hot AND-OR data select from the granted channel
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (w_grant[i]) begin
        w_sel_data = w_sel_data | i_in_data[slice_lo(i, WIDTH) +: WIDTH];
      end
    end
  end

  // Output stage: load on transfer, drop valid when drained, otherwise hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_data  <= w_sel_data;
      r_out_ch    <= w_sel_idx;
      r_out_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Pointer moves past whichever channel was served, in either mode
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_sel_idx == SEL_W'(N_CH - 1)) ? '0 : w_sel_idx + SEL_W'(1);
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_ch    = r_out_ch;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed self-checking bench for mux_rr_reg (4-channel main DUT plus a
// 3-channel instance for out-of-range select).
module tb_mux_rr_reg;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

  int errors = 0;
  int checks = 0;

  mux_rr_reg #(.N_CH(4), .WIDTH(8), .SEL_W(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mode      (mode),
    .i_sel       (sel),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_data  (out_data),
    .o_out_ch    (out_ch),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  mux_rr_reg #(.N_CH(3), .WIDTH(8), .SEL_W(2)) dut3 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mode      (mode3),
    .i_sel       (sel3),
    .i_in_data   (in_data3),
    .i_in_valid  (in_valid3),
    .o_in_ready  (in_ready3),
    .o_out_data  (out_data3),
    .o_out_ch    (out_ch3),
    .o_out_valid (out_valid3),
    .i_out_ready (out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    #3;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = 32'h44_33_22_11;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #2;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0000", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
               out_valid, out_data, out_ch);
    end
    step();
    rst_n = 1'b1;
    #1;
    // Load one beat from ch0, then pull reset mid-cycle
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL reset_preload: got v=%b d=%h want v=1 d=11", out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
               out_valid, out_data, out_ch);
    end
    in_valid = 4'b0000;
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL idle_in_ready: got %b want 0000", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_out_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    mode     = 1'b0;
    sel      = 2'd2;
    in_data  = 32'h44_A5_22_11;
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL fixed_in_ready: got %b want 0100", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      errors++;
      $display("FAIL fixed_beat: got v=%b d=%h ch=%0d want v=1 d=a5 ch=2",
               out_valid, out_data, out_ch);
    end
    sel      = 2'd3;
    in_valid = 4'b0111;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL fixed_no_grant: got %b want 0000", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      errors++;
      $display("FAIL fixed_drain: got v=%b d=%h ch=%0d want v=0 d=a5 ch=2",
               out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_rr_fair();
    logic [1:0] exp_a [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] exp_b [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [7:0] dat   [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
    do_reset();
    mode     = 1'b1;
    in_data  = {dat[3], dat[2], dat[1], dat[0]};
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_a[i] || out_data !== dat[exp_a[i]]) begin
        errors++;
        $display("FAIL rr_all[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 i, out_valid, out_ch, out_data, exp_a[i], dat[exp_a[i]]);
      end
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_b[i] || out_data !== dat[exp_b[i]]) begin
        errors++;
        $display("FAIL rr_1010[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 i, out_valid, out_ch, out_data, exp_b[i], dat[exp_b[i]]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mode      = 1'b0;
    sel       = 2'd1;
    in_data   = 32'h00_5A_3C_00;
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_first_ready: got %b want 0010", in_ready);
    end
    step();
    sel      = 2'd2;
    in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd1 || in_ready !== 4'b0000)
      begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d rdy=%b want v=1 d=3c ch=1 rdy=0000",
                 i, out_valid, out_data, out_ch, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 0100", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_ch !== 2'd2) begin
      errors++;
      $display("FAIL bp_no_bubble: got v=%b d=%h ch=%0d want v=1 d=5a ch=2",
               out_valid, out_data, out_ch);
    end
    in_valid = 4'b0000;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode     = 1'b0;
    sel      = 2'd1;
    in_data  = 32'h44_33_22_11;
    in_valid = 4'b0010;
    step();
    checks++;
    if (out_ch !== 2'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ms_fixed: got v=%b ch=%0d want v=1 ch=1", out_valid, out_ch);
    end
    mode     = 1'b1;
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL ms_rr_ready: got %b want 0100", in_ready);
    end
    step();
    checks++;
    if (out_ch !== 2'd2 || out_data !== 8'h33) begin
      errors++;
      $display("FAIL ms_rr_beat: got ch=%0d d=%h want ch=2 d=33", out_ch, out_data);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mode     = 1'b0;
    sel      = 2'd2;
    in_data  = 32'h44_33_22_11;
    in_valid = 4'b0100;
    step();
    mode     = 1'b1;
    in_valid = 4'b0001;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_ready: got %b want 0001", in_ready);
    end
    step();
    checks++;
    if (out_ch !== 2'd0 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL wrap_beat: got ch=%0d d=%h want ch=0 d=11", out_ch, out_data);
    end
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_ptr: got %b want 0010", in_ready);
    end
    in_valid = 4'b0000;
    step();
  endtask

  task automatic test_out_of_range();
    do_reset();
    mode3      = 1'b0;
    sel3       = 2'd3;
    in_data3   = 24'hCC_BB_AA;
    in_valid3  = 3'b111;
    out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
        errors++;
        $display("FAIL oor[%0d]: got rdy=%b v=%b want rdy=000 v=0", i, in_ready3, out_valid3);
      end
      step();
    end
    sel3 = 2'd2;
    #1;
    checks++;
    if (in_ready3 !== 3'b100) begin
      errors++;
      $display("FAIL oor_inrange: got %b want 100", in_ready3);
    end
    step();
    checks++;
    if (out_valid3 !== 1'b1 || out_data3 !== 8'hCC || out_ch3 !== 2'd2) begin
      errors++;
      $display("FAIL oor_beat: got v=%b d=%h ch=%0d want v=1 d=cc ch=2",
               out_valid3, out_data3, out_ch3);
    end
    in_valid3 = 3'b000;
  endtask

  initial begin
    rst_n      = 1'b0;
    mode       = 1'b0;
    sel        = 2'd0;
    in_data    = '0;
    in_valid   = '0;
    out_ready  = 1'b1;
    mode3      = 1'b0;
    sel3       = 2'd0;
    in_data3   = '0;
    in_valid3  = '0;
    out_ready3 = 1'b1;
    test_reset();
    test_fixed();
    test_rr_fair();
    test_back_to_back();
    test_mode_switch();
    test_wrap();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
Parametrised N-channel, WIDTH-bit multiplexer with a registered output and a valid/ready handshake per channel.
- Two selection modes:
  - fixed select: the channel is chosen by the sel port, like the existing 2-to-1 muxes.
  - round-robin arbitration among requesting channels.
- Sits between several producer streams and one consumer.
- Replaces ad-hoc 2-to-1 mux chains wherever back-pressure or fair sharing is needed.

Parameters:
- N_CH, 4, number of input channels; allowed range 2..16.
- WIDTH, 8, data width per channel in bits.
- SEL_W, 2, width of sel and out_ch; must satisfy 2^SEL_W >= N_CH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- in_data  input  N_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; combinational.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is then all-zero because no grant can issue while rst_n is low.
- Stage enable: load = !out_valid | out_ready.

Grant (combinational, one-hot grant[N_CH-1:0]):
- mode=0: grant[sel]=1 if sel<N_CH and in_valid[sel]; otherwise no grant. sel>=N_CH never grants.
- mode=1: grant = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_CH.
- No grant when in_valid is all zero.

Handshake:
- in_ready[i] = grant[i] & load.
- A transfer on channel i occurs when in_valid[i] & in_ready[i].
- At most one channel transfers per cycle.
- A non-granted channel must keep its valid and data stable; the block neither drops nor duplicates beats.

Output register, evaluated at the clock edge:
- Transfer on channel k: out_data <= in_data[k], out_ch <= k, out_valid <= 1.
- Else if out_ready: out_valid <= 0. out_data and out_ch hold their last values.
- Else: all outputs hold.
- While out_valid & !out_ready, out_data and out_ch are stable.
- Latency: input transfer to out_valid is 1 cycle.
- Throughput: 1 beat/cycle while out_ready stays high.

Round-robin pointer:
- On a transfer from channel k, rr_ptr <= (k==N_CH-1) ? 0 : k+1.
- Otherwise rr_ptr holds.
- rr_ptr also updates on fixed-mode transfers, so a switch to mode=1 continues fairly from the last served channel.

Mode or sel change mid-stream:
- Affects only the next grant.
- A beat already in the output register is unaffected.

Starvation bound: in mode=1, a channel holding valid is served within N_CH transfers.

Simultaneous drain and fill: out_valid & out_ready together with a new transfer loads the new beat, so out_valid stays 1 with no bubble.

Reset mid-operation: the held beat is discarded and the pointer returns to 0.

Decomposition:
- Shared header mux_defs.vh:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - Default N_CH, WIDTH and SEL_W.
  - Macro for the packed-slice index.
- Sub-module rr_pick (parameters N_CH, SEL_W):
  - Inputs: req vector, start pointer.
  - Outputs: one-hot grant, encoded index, any flag.
  - Purely combinational; implemented as a double-width rotate-and-priority search.
  - Unit-testable on its own.
- Top-level mux_rr_reg contains the mode mux, handshake logic, output register and rr_ptr register.

Test Plan:
1. Reset and idle. Apply rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, out_data=0 and out_ch=0 immediately, before the next edge. After release with in_valid=0 -> in_ready=0 and out_valid stays 0.
2. Fixed mode. N_CH=4, mode=0, sel=2, in_data ch2=0xA5, all in_valid=1, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=0xA5, out_ch=2. Set sel=3 with in_valid[3]=0 -> no grant, out_valid falls to 0.
3. Round-robin fairness. mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. Then in_valid=4'b1010 -> sequence 1,3,1,3.
4. Back-pressure. Beat 0x3C held from ch1 with out_ready=0 for 3 cycles -> out_data=0x3C and out_ch=1 stable, in_ready=0. Raise out_ready with ch2 valid -> in_ready[2]=1 in the same cycle, next beat arrives with no bubble cycle.
5. Mode switch. Run mode=0, sel=1, with one transfer from ch1. Switch to mode=1 with in_valid=4'b1111 -> next grant is ch2, continuing from rr_ptr=2.
6. Wrap and out-of-range. mode=1, rr_ptr=3, in_valid=4'b0001 -> ch0 granted and rr_ptr becomes 1. mode=0 with sel=3 while N_CH=3 (SEL_W=2) -> no grant ever issues.
